// File: rtl/data_cache_wb_pkg.sv
// Shared definitions for the write-back data cache: geometry, FSM encoding, address split.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package data_cache_wb_pkg;

    // Default cache geometry: 8 words per line, 16 sets, remaining bits are tag
    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 4;
    localparam int DEF_TAG_ADDR_LEN  = 32 - 2 - DEF_LINE_ADDR_LEN - DEF_SET_ADDR_LEN;
    localparam int DEF_LINE_WORDS    = 1 << DEF_LINE_ADDR_LEN;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE      = 2'd0;
    localparam state_t WRITEBACK = 2'd1;
    localparam state_t REFILL    = 2'd2;

    // Extract a right-justified bit field of the given width from a byte address
    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Storage for the cache: data words, per-set tag, valid and dirty bits.
// Latency: reads are combinational; writes land at the next clk edge.
// Backpressure: none, every write presented is committed.
module cache_line_store
    import data_cache_wb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  set,
    input  logic [LINE_ADDR_LEN-1:0] rd_offset,
    output logic [31:0]              rd_word,
    output logic [TAG_ADDR_LEN-1:0]  line_tag,
    output logic                     line_valid,
    output logic                     line_dirty,
    input  logic                     wr_en,
    input  logic [LINE_ADDR_LEN-1:0] wr_offset,
    input  logic [3:0]               wr_be,
    input  logic [31:0]              wr_word,
    input  logic                     mark_dirty,
    input  logic                     fill_done,
    input  logic [TAG_ADDR_LEN-1:0]  fill_tag
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int WORDS = 1 << LINE_ADDR_LEN;

    logic [31:0]             data_arr [SETS][WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_arr  [SETS];
    logic [SETS-1:0]         valid_bits;
    logic [SETS-1:0]         dirty_bits;

    assign rd_word    = data_arr[set][rd_offset];
    assign line_tag   = tag_arr[set];
    assign line_valid = valid_bits[set];
    assign line_dirty = dirty_bits[set];

    // Byte-enabled data write; the array itself is never cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_arr[set][wr_offset][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Tag is installed when the last word of a refill arrives
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[set] <= fill_tag;
        end
    end

    // Valid/dirty: reset invalidates every line, so an abandoned refill never becomes visible
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_done) begin
            valid_bits[set] <= 1'b1;
            dirty_bits[set] <= 1'b0;
        end else if (mark_dirty) begin
            dirty_bits[set] <= 1'b1;
        end
    end

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache for the MEM-stage load/store port.
// Latency: hits complete in the request cycle; misses stall via miss until writeback+refill finish.
// Backpressure: miss holds the pipeline; each memory word waits for its one-cycle mem_ack.
module data_cache_wb
    import data_cache_wb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd_req,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int SET_LSB = LINE_ADDR_LEN + 2;
    localparam int TAG_LSB = SET_LSB + SET_ADDR_LEN;

    // Address split
    logic [31:0]              off_f, set_f, tag_f;
    logic [LINE_ADDR_LEN-1:0] offset;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     unused_addr_bits;

    assign off_f  = addr_field(addr, 2, LINE_ADDR_LEN);
    assign set_f  = addr_field(addr, SET_LSB, SET_ADDR_LEN);
    assign tag_f  = addr_field(addr, TAG_LSB, TAG_ADDR_LEN);
    assign offset = off_f[LINE_ADDR_LEN-1:0];
    assign set    = set_f[SET_ADDR_LEN-1:0];
    assign tag    = tag_f[TAG_ADDR_LEN-1:0];
    assign unused_addr_bits = ^{addr[1:0], off_f[31:LINE_ADDR_LEN],
                                set_f[31:SET_ADDR_LEN], tag_f[31:TAG_ADDR_LEN]};

    // Controller state
    state_t                   state;
    logic [LINE_ADDR_LEN-1:0] word_cnt;
    logic                     access, hit, last_word;

    // Store interface
    logic [LINE_ADDR_LEN-1:0] rd_offset, st_wr_offset;
    logic [31:0]              rd_word, st_wr_word;
    logic [TAG_ADDR_LEN-1:0]  line_tag;
    logic                     line_valid, line_dirty;
    logic                     st_wr_en, st_mark_dirty, st_fill_done;
    logic [3:0]               st_wr_be;

    assign access    = rd_req | (|wr_be);
    assign hit       = line_valid && (line_tag == tag);
    assign last_word = &word_cnt;

    // Stall whenever a transfer is running, or a new access misses
    assign miss = (state != IDLE) | (access & ~hit);

    // During writeback the read port walks the victim line
    assign rd_offset = (state == WRITEBACK) ? word_cnt : offset;
    assign rd_data   = (state == IDLE && rd_req && hit) ? rd_word : 32'd0;

    // Memory port is a pure function of state, so it is held steady until the ack
    assign mem_req   = (state == WRITEBACK) || (state == REFILL);
    assign mem_we    = (state == WRITEBACK);
    assign mem_addr  = (state == WRITEBACK) ? {line_tag, set, word_cnt, 2'b00} :
                       (state == REFILL)    ? {tag, set, word_cnt, 2'b00} : 32'd0;
    assign mem_wdata = (state == WRITEBACK) ? rd_word : 32'd0;

    // Select the store's write source: a store hit or an incoming refill word
    always_comb begin
        st_wr_en      = 1'b0;
        st_wr_offset  = offset;
        st_wr_be      = wr_be;
        st_wr_word    = wr_data;
        st_mark_dirty = 1'b0;
        st_fill_done  = 1'b0;
        if (state == IDLE && hit && (|wr_be)) begin
            st_wr_en      = 1'b1;
            st_mark_dirty = 1'b1;
        end else if (state == REFILL && mem_ack) begin
            st_wr_en     = 1'b1;
            st_wr_offset = word_cnt;
            st_wr_be     = 4'hF;
            st_wr_word   = mem_rdata;
            st_fill_done = last_word;
        end
    end

    // Miss handling FSM and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        word_cnt <= '0;
                        state    <= (line_valid && line_dirty) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Performance counters; only accesses seen in IDLE are classified
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state == IDLE && access) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end

    cache_line_store #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .set        (set),
        .rd_offset  (rd_offset),
        .rd_word    (rd_word),
        .line_tag   (line_tag),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .wr_en      (st_wr_en),
        .wr_offset  (st_wr_offset),
        .wr_be      (st_wr_be),
        .wr_word    (st_wr_word),
        .mark_dirty (st_mark_dirty),
        .fill_done  (st_fill_done),
        .fill_tag   (tag)
    );

endmodule

// File: tb/tb_data_cache_wb.sv
// Bench for data_cache_wb: directed accesses against a line-level cache model and a memory responder.
// Latency: checks every cycle at the falling edge.
// Backpressure: the responder acks each word after a programmable delay.
`timescale 1ns/1ps
module tb_data_cache_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wr_data, rd_data, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
    logic        rd_req, miss, mem_req, mem_we, mem_ack;
    logic [3:0]  wr_be;

    always #5 clk = ~clk;

    data_cache_wb dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .rd_req     (rd_req),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .miss       (miss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    op_t         exp_ops[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] resp_mem  [logic [31:0]];
    bit          m_valid [16];
    bit          m_dirty [16];
    int unsigned m_tag   [16];
    logic [31:0] m_data  [16][8];
    logic [31:0] exp_hits, exp_misses, exp_rd, last_rd;
    bit          req_active, first_cycle, in_rst;
    int          ack_delay, acks_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : a;
    endfunction

    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : a;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
    endfunction

    // Line-level model: decides hit/miss, queues the expected memory words, updates the line
    function automatic bit model_access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int unsigned s, o, t;
        bit          h;
        op_t         op;
        s = (a >> 5) & 15;
        o = (a >> 2) & 7;
        t = a >> 9;
        h = m_valid[s] && (m_tag[s] == t);
        if (!h) begin
            if (m_valid[s] && m_dirty[s]) begin
                for (int w = 0; w < 8; w++) begin
                    op.we   = 1'b1;
                    op.addr = (m_tag[s] << 9) | (s << 5) | (w << 2);
                    op.data = m_data[s][w];
                    exp_ops.push_back(op);
                    model_mem[op.addr] = op.data;
                end
            end
            for (int w = 0; w < 8; w++) begin
                op.we   = 1'b0;
                op.addr = (t << 9) | (s << 5) | (w << 2);
                op.data = 32'd0;
                exp_ops.push_back(op);
                m_data[s][w] = model_rd(op.addr);
            end
            m_tag[s]   = t;
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
        end
        exp_rd = m_data[s][o];
        if (be != 4'd0) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_data[s][o][8*b +: 8] = wd[8*b +: 8];
            end
            m_dirty[s] = 1'b1;
        end
        return h;
    endfunction

    // Memory responder: acks each word after ack_delay waiting cycles
    initial begin : responder
        int waitc;
        waitc     = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            if (rst || !mem_req) begin
                waitc = 0;
            end else if (waitc >= ack_delay) begin
                mem_ack = 1'b1;
                waitc   = 0;
                if (mem_we) resp_mem[mem_addr] = mem_wdata;
                else        mem_rdata = resp_rd(mem_addr);
            end else begin
                waitc++;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin : compare
        bit pend;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                pend = (exp_ops.size() != 0);
                check("miss", 32'(miss), 32'(pend));
                check("mem_req", 32'(mem_req), 32'(pend && !first_cycle));
                check("hit_count", hit_count, exp_hits);
                check("miss_count", miss_count, exp_misses);
                if (pend && !first_cycle) begin
                    check("mem_we", 32'(mem_we), 32'(exp_ops[0].we));
                    check("mem_addr", mem_addr, exp_ops[0].addr);
                    if (exp_ops[0].we) check("mem_wdata", mem_wdata, exp_ops[0].data);
                    if (mem_ack) begin
                        void'(exp_ops.pop_front());
                        acks_seen++;
                    end
                end
                if (req_active && !pend && rd_req) begin
                    check("rd_data", rd_data, exp_rd);
                    last_rd = rd_data;
                end
            end
        end
    end

    // One complete access: issue, wait for any transfer, then the hit cycle
    task automatic access(input logic [31:0] a, input bit rd, input logic [3:0] be, input logic [31:0] wd);
        bit h;
        int guard;
        h = model_access(a, be, wd);
        addr       = a;
        rd_req     = rd;
        wr_be      = be;
        wr_data    = wd;
        req_active = 1'b1;
        if (!h) begin
            first_cycle = 1'b1;
            @(posedge clk); #1;
            first_cycle = 1'b0;
            exp_misses++;
            guard = 0;
            while (exp_ops.size() != 0 && guard < 2000) begin
                @(posedge clk); #1;
                guard++;
            end
            check("ops_drained", exp_ops.size(), 0);
            exp_ops.delete();
        end
        @(posedge clk); #1;
        exp_hits++;
        rd_req     = 1'b0;
        wr_be      = 4'd0;
        req_active = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int guard;
        rst = 1'b1; addr = 32'd0; rd_req = 1'b0; wr_be = 4'd0; wr_data = 32'd0;
        req_active = 1'b0; first_cycle = 1'b0; in_rst = 1'b1; ack_delay = 0;
        exp_hits = 32'd0; exp_misses = 32'd0; exp_rd = 32'd0; last_rd = 32'd0; acks_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_rst = 1'b0;
        #1;
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        @(posedge clk); #1;

        // Cold read miss: refill 0x00..0x1C
        access(32'h10, 1'b1, 4'd0, 32'd0);
        check("t1_rd", last_rd, 32'h10);
        check("t1_misses", miss_count, 32'd1);
        check("t1_hits", hit_count, 32'd1);

        // Read hit in same line
        access(32'h14, 1'b1, 4'd0, 32'd0);
        check("t2_rd", last_rd, 32'h14);
        check("t2_hits", hit_count, 32'd2);

        // Partial store then read back
        access(32'h10, 1'b0, 4'b0011, 32'hAABBCCDD);
        access(32'h10, 1'b1, 4'd0, 32'd0);
        check("t3_rd", last_rd, 32'h0000CCDD);

        // Simultaneous read and write: read sees the old word
        access(32'h18, 1'b1, 4'b1000, 32'h11223344);
        check("t3b_rd_prewrite", last_rd, 32'h18);
        access(32'h18, 1'b1, 4'd0, 32'd0);
        check("t3b_rd_merged", last_rd, 32'h11000018);

        // Conflict miss on set 0 with dirty victim
        access(32'h200, 1'b1, 4'd0, 32'd0);
        check("t4_rd", last_rd, 32'h200);
        check("t4_misses", miss_count, 32'd2);
        check("t4_wb_word10", resp_rd(32'h10), 32'h0000CCDD);
        check("t4_wb_word18", resp_rd(32'h18), 32'h11000018);

        // Slow memory: dirty the 0x200 line, then evict it with delayed acks
        ack_delay = 5;
        access(32'h210, 1'b0, 4'b1111, 32'hDEADBEEF);
        access(32'h10, 1'b1, 4'd0, 32'd0);
        check("t5_rd", last_rd, 32'h0000CCDD);
        check("t5_wb_word210", resp_rd(32'h210), 32'hDEADBEEF);
        check("t5_misses", miss_count, 32'd3);
        ack_delay = 0;

        // Reset after the third refill ack
        void'(model_access(32'h200, 4'd0, 32'd0));
        addr = 32'h200; rd_req = 1'b1; req_active = 1'b1; first_cycle = 1'b1;
        acks_seen = 0;
        @(posedge clk); #1;
        first_cycle = 1'b0;
        exp_misses++;
        guard = 0;
        while (acks_seen < 3 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_acks_before_rst", 32'(acks_seen), 32'd3);
        rst = 1'b1; in_rst = 1'b1;
        rd_req = 1'b0; req_active = 1'b0;
        exp_ops.delete();
        model_reset();
        exp_hits = 32'd0; exp_misses = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0; in_rst = 1'b0;
        #1;
        check("t6_mem_req", 32'(mem_req), 32'd0);
        check("t6_miss", 32'(miss), 32'd0);
        check("t6_hits", hit_count, 32'd0);
        check("t6_misses", miss_count, 32'd0);
        @(posedge clk); #1;
        access(32'h200, 1'b1, 4'd0, 32'd0);
        check("t6_rd", last_rd, 32'h200);
        check("t6_misses_after", miss_count, 32'd1);
        check("t6_hits_after", hit_count, 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
